// File: rtl/azimuth_sweep_loader.sv
// azimuth_sweep_loader: assembles one sweep's range-bin bitmap from an
// AXI4-Stream word sequence into a back buffer, and hands it to the azimuth
// generator's registered DATA bus on each sweep trigger (double buffered).
module azimuth_sweep_loader #(
    parameter int SIZE   = 3200,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              i_SYS_CLK,
    input  logic              i_SYS_RST,
    input  logic              i_EN,
    input  logic              i_TRIG,
    input  logic [WORD_W-1:0] i_S_AXIS_TDATA,
    input  logic              i_S_AXIS_TVALID,
    output logic              o_S_AXIS_TREADY,
    input  logic              i_S_AXIS_TLAST,
    output logic [SIZE-1:0]   o_DATA,
    output logic              o_LOADED,
    output logic              o_SWAP,
    output logic              o_UNDERRUN,
    output logic              o_FRAME_ERR,
    output logic [CNT_W-1:0]  o_UNDERRUN_CNT,
    output logic [CNT_W-1:0]  o_FRAME_ERR_CNT
);

    localparam int NWORDS = (SIZE + WORD_W - 1) / WORD_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic {ST_FILL = 1'b0, ST_FULL = 1'b1} state_t;

    state_t                     r_state;
    logic [IDX_W-1:0]           r_idx;
    logic [NWORDS*WORD_W-1:0]   r_buf;
    logic [SIZE-1:0]            r_data;
    logic                       r_swap;
    logic                       r_underrun;
    logic                       r_frame_err;
    logic [CNT_W-1:0]           r_ucnt;
    logic [CNT_W-1:0]           r_fcnt;

    logic                       w_ready;
    logic                       w_acc;
    logic                       w_last_word;

    // Ready is a pure decode of the state register; it never looks at TVALID.
    assign w_ready     = i_EN && (r_state == ST_FILL) && !i_SYS_RST;
    assign w_acc       = w_ready && i_S_AXIS_TVALID;
    assign w_last_word = (r_idx == LAST_IDX);

    // Back buffer: write the accepted word into its slot; contents need no reset.
    always_ff @(posedge i_SYS_CLK) begin
        for (int k = 0; k < NWORDS; k++) begin
            if (w_acc && (r_idx == IDX_W'(k)))
                r_buf[k*WORD_W +: WORD_W] <= i_S_AXIS_TDATA;
        end
    end

    // Fill/full state machine, trigger handling, status pulses and counters.
    always_ff @(posedge i_SYS_CLK) begin
        if (i_SYS_RST) begin
            r_state     <= ST_FILL;
            r_idx       <= '0;
            r_data      <= '0;
            r_swap      <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
            r_ucnt      <= '0;
            r_fcnt      <= '0;
        end else begin
            r_swap      <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
            if (!i_EN) begin
                // Flush: blank the generator and drop any partial frame.
                r_data  <= '0;
                r_state <= ST_FILL;
                r_idx   <= '0;
            end else begin
                if (i_TRIG) begin
                    if (r_state == ST_FULL) begin
                        r_data  <= r_buf[SIZE-1:0];
                        r_swap  <= 1'b1;
                        r_state <= ST_FILL;
                        r_idx   <= '0;
                    end else begin
                        // Nothing complete to show: blank rather than replay stale targets.
                        r_data     <= '0;
                        r_underrun <= 1'b1;
                        if (r_ucnt != '1)
                            r_ucnt <= r_ucnt + 1'b1;
                    end
                end
                // Acceptance only happens in FILL, so it never collides with a swap.
                if (w_acc) begin
                    if (w_last_word) begin
                        // Word count is authoritative: commit even without TLAST.
                        r_state <= ST_FULL;
                        r_idx   <= '0;
                        if (!i_S_AXIS_TLAST) begin
                            r_frame_err <= 1'b1;
                            if (r_fcnt != '1)
                                r_fcnt <= r_fcnt + 1'b1;
                        end
                    end else if (i_S_AXIS_TLAST) begin
                        // Short frame: discard and restart at word 0.
                        r_idx       <= '0;
                        r_frame_err <= 1'b1;
                        if (r_fcnt != '1)
                            r_fcnt <= r_fcnt + 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
            end
        end
    end

    assign o_S_AXIS_TREADY = w_ready;
    assign o_DATA          = r_data;
    assign o_LOADED        = (r_state == ST_FULL);
    assign o_SWAP          = r_swap;
    assign o_UNDERRUN      = r_underrun;
    assign o_FRAME_ERR     = r_frame_err;
    assign o_UNDERRUN_CNT  = r_ucnt;
    assign o_FRAME_ERR_CNT = r_fcnt;

endmodule

// File: tb/tb_azimuth_sweep_loader.sv
// Directed bench: a small instance (SIZE=64, two words, 2-bit counters to
// reach saturation) and a default-size instance (100 words).
module tb_azimuth_sweep_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- small instance ----------------
    logic        s_en, s_trig, s_tvalid, s_tlast, s_tready;
    logic [31:0] s_tdata;
    logic [63:0] s_data;
    logic        s_loaded, s_swap, s_under, s_ferr;
    logic [1:0]  s_ucnt, s_fcnt;

    azimuth_sweep_loader #(.SIZE(64), .WORD_W(32), .CNT_W(2)) dut_s (
        .i_SYS_CLK(clk), .i_SYS_RST(rst), .i_EN(s_en), .i_TRIG(s_trig),
        .i_S_AXIS_TDATA(s_tdata), .i_S_AXIS_TVALID(s_tvalid),
        .o_S_AXIS_TREADY(s_tready), .i_S_AXIS_TLAST(s_tlast),
        .o_DATA(s_data), .o_LOADED(s_loaded), .o_SWAP(s_swap),
        .o_UNDERRUN(s_under), .o_FRAME_ERR(s_ferr),
        .o_UNDERRUN_CNT(s_ucnt), .o_FRAME_ERR_CNT(s_fcnt)
    );

    // ---------------- default instance ----------------
    logic          d_en, d_trig, d_tvalid, d_tlast, d_tready;
    logic [31:0]   d_tdata;
    logic [3199:0] d_data;
    logic          d_loaded, d_swap, d_under, d_ferr;
    logic [15:0]   d_ucnt, d_fcnt;
    logic [3199:0] d_exp;

    azimuth_sweep_loader dut_d (
        .i_SYS_CLK(clk), .i_SYS_RST(rst), .i_EN(d_en), .i_TRIG(d_trig),
        .i_S_AXIS_TDATA(d_tdata), .i_S_AXIS_TVALID(d_tvalid),
        .o_S_AXIS_TREADY(d_tready), .i_S_AXIS_TLAST(d_tlast),
        .o_DATA(d_data), .o_LOADED(d_loaded), .o_SWAP(d_swap),
        .o_UNDERRUN(d_under), .o_FRAME_ERR(d_ferr),
        .o_UNDERRUN_CNT(d_ucnt), .o_FRAME_ERR_CNT(d_fcnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic s_send(input logic [31:0] w, input logic last);
        s_tdata = w; s_tlast = last; s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic s_pulse_trig();
        s_trig = 1'b1;
        tick();
        s_trig = 1'b0;
    endtask

    task automatic d_send(input logic [31:0] w, input logic last);
        d_tdata = w; d_tlast = last; d_tvalid = 1'b1;
        tick();
        d_tvalid = 1'b0; d_tlast = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        s_en = 0; s_trig = 0; s_tvalid = 0; s_tlast = 0; s_tdata = '0;
        d_en = 0; d_trig = 0; d_tvalid = 0; d_tlast = 0; d_tdata = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_data",   s_data,   64'h0);
        chk("rst_loaded", s_loaded, 0);
        chk("rst_swap",   s_swap,   0);
        chk("rst_under",  s_under,  0);
        chk("rst_ferr",   s_ferr,   0);
        chk("rst_ucnt",   s_ucnt,   0);
        chk("rst_fcnt",   s_fcnt,   0);
        chk("rst_tready_en0", s_tready, 0);
        s_en = 1'b1;
        #1;
        chk("tready_en1", s_tready, 1);

        // Basic frame load and swap
        s_send(32'hAAAA5555, 1'b0);
        chk("t1_loaded_w0", s_loaded, 0);
        s_send(32'h0F0F00FF, 1'b1);
        chk("t1_loaded", s_loaded, 1);
        chk("t1_tready_full", s_tready, 0);
        chk("t1_data_pre", s_data, 64'h0);
        chk("t1_ferr", s_ferr, 0);
        s_pulse_trig();
        chk("t1_data", s_data, 64'h0F0F00FF_AAAA5555);
        chk("t1_swap", s_swap, 1);
        chk("t1_loaded_after", s_loaded, 0);
        chk("t1_tready_after", s_tready, 1);
        tick();
        chk("t1_swap_off", s_swap, 0);

        // Underrun with a partial frame kept
        s_send(32'h11111111, 1'b0);
        s_pulse_trig();
        chk("t2_data_blank", s_data, 64'h0);
        chk("t2_under", s_under, 1);
        chk("t2_ucnt", s_ucnt, 1);
        tick();
        chk("t2_under_off", s_under, 0);
        s_send(32'h22222222, 1'b1);
        chk("t2_loaded", s_loaded, 1);
        s_pulse_trig();
        chk("t2_data", s_data, 64'h22222222_11111111);
        chk("t2_swap", s_swap, 1);

        // Early TLAST discards the partial frame
        s_send(32'h33333333, 1'b1);
        chk("t3_ferr", s_ferr, 1);
        chk("t3_fcnt", s_fcnt, 1);
        chk("t3_loaded", s_loaded, 0);
        tick();
        chk("t3_ferr_off", s_ferr, 0);
        s_send(32'h44444444, 1'b0);
        chk("t3_idx_reset", s_loaded, 0);
        s_send(32'h55555555, 1'b1);
        chk("t3_loaded2", s_loaded, 1);
        s_pulse_trig();
        chk("t3_data", s_data, 64'h55555555_44444444);

        // Missing TLAST still commits the frame
        s_send(32'h66666666, 1'b0);
        s_send(32'h77777777, 1'b0);
        chk("t4_ferr", s_ferr, 1);
        chk("t4_fcnt", s_fcnt, 2);
        chk("t4_loaded", s_loaded, 1);
        s_pulse_trig();
        chk("t4_data", s_data, 64'h77777777_66666666);

        // TRIG coincident with the final handshake
        s_send(32'h88888888, 1'b0);
        s_tdata = 32'h99999999; s_tlast = 1'b1; s_tvalid = 1'b1; s_trig = 1'b1;
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0; s_trig = 1'b0;
        chk("t5_under", s_under, 1);
        chk("t5_ucnt", s_ucnt, 2);
        chk("t5_data", s_data, 64'h0);
        chk("t5_loaded", s_loaded, 1);
        chk("t5_swap", s_swap, 0);
        tick();
        s_pulse_trig();
        chk("t5_swap2", s_swap, 1);
        chk("t5_data2", s_data, 64'h99999999_88888888);

        // EN low mid-frame flushes, TRIG ignored
        s_send(32'hAAAAAAAA, 1'b0);
        s_en = 1'b0;
        tick();
        chk("t6_data", s_data, 64'h0);
        chk("t6_tready", s_tready, 0);
        s_pulse_trig();
        chk("t6_trig_ign", s_under, 0);
        chk("t6_ucnt_hold", s_ucnt, 2);
        s_en = 1'b1;
        s_send(32'hBBBBBBBB, 1'b0);
        chk("t6_idx_clr", s_loaded, 0);
        s_send(32'hCCCCCCCC, 1'b1);
        s_pulse_trig();
        chk("t6_data2", s_data, 64'hCCCCCCCC_BBBBBBBB);

        // Counter saturation at 3 with CNT_W=2
        s_pulse_trig();
        chk("t7_ucnt3", s_ucnt, 3);
        s_pulse_trig();
        chk("t7_ucnt_sat", s_ucnt, 3);
        chk("t7_under", s_under, 1);

        // ---------------- default size ----------------
        for (int i = 0; i < 100; i++) d_exp[i*32 +: 32] = 32'(i);
        d_en = 1'b1;
        for (int i = 0; i < 50; i++) d_send(32'(i + 1000), 1'b0);
        d_en = 1'b0;
        tick();
        chk("d_en_data", d_data[63:0], 64'h0);
        chk("d_en_tready", d_tready, 0);
        d_en = 1'b1;
        for (int i = 0; i < 99; i++) d_send(32'(i), 1'b0);
        chk("d_idx_clr", d_loaded, 0);
        d_send(32'd99, 1'b1);
        chk("d_loaded", d_loaded, 1);
        chk("d_ferr", d_ferr, 0);
        d_trig = 1'b1;
        tick();
        d_trig = 1'b0;
        chk("d_swap", d_swap, 1);
        chk("d_data_lo", d_data[31:0], 0);
        chk("d_data_hi", d_data[3199:3168], 99);
        chk("d_data_full", d_data === d_exp, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/azimuth_sweep_loader.md
Name: azimuth_sweep_loader

Overview:
- Upstream feeder for the azimuth signal generator.
- Receives one sweep's range-bin bitmap as an AXI4-Stream word sequence and assembles it into a back buffer.
- On each sweep trigger, transfers the back buffer to the registered SIZE-bit DATA bus that the generator indexes.
- Double buffering lets the next sweep load while the current sweep plays out.

Parameters:
- SIZE, 3200, range bins per sweep; width of DATA.
- WORD_W, 32, stream word width.
- CNT_W, 16, width of the underrun and frame-error counters.
- Derived: NWORDS = ceil(SIZE/WORD_W) (100 at defaults). IDX_W = clog2(NWORDS), minimum 1.

Ports:
- SYS_CLK  in  1  system clock (100 MHz); the only clock.
- SYS_RST  in  1  reset, synchronous, active-high.
- EN  in  1  block enable (active high).
- TRIG  in  1  sweep start; one SYS_CLK-cycle pulse; the same pulse drives the generator.
- S_AXIS_TDATA  in  WORD_W  bitmap word.
- S_AXIS_TVALID  in  1  word valid.
- S_AXIS_TREADY  out  1  word accepted when TVALID and TREADY are both high.
- S_AXIS_TLAST  in  1  marks the last word of a sweep.
- DATA  out  SIZE  registered sweep bitmap to the generator.
- LOADED  out  1  back buffer holds a complete sweep.
- SWAP  out  1  one-cycle pulse when a full back buffer is transferred.
- UNDERRUN  out  1  one-cycle pulse when TRIG arrives and no full back buffer is available.
- FRAME_ERR  out  1  one-cycle pulse on a TLAST mismatch.
- UNDERRUN_CNT  out  CNT_W  saturating count of UNDERRUN pulses.
- FRAME_ERR_CNT  out  CNT_W  saturating count of FRAME_ERR pulses.

Behaviour:
- Reset: all outputs are registered. Reset values:
  - DATA = 0, LOADED = 0, SWAP = 0, UNDERRUN = 0, FRAME_ERR = 0.
  - Both counters = 0, state = FILL, word index = 0.
  - Back buffer contents are don't-care.
  - Reset has priority over everything. Asserting it mid-frame discards the partial frame.
- Handshake:
  - S_AXIS_TREADY = EN && state==FILL && !SYS_RST, decoded combinationally from the state register.
  - TREADY never depends on TVALID.
- State FILL (LOADED = 0):
  - Each accepted word k is written to back buffer bits [k*WORD_W +: WORD_W]. Bits at index ≥ SIZE are discarded.
  - The word index increments after each accepted word.
  - When word NWORDS-1 is accepted, the next state is FULL.
- TLAST rules:
  - TLAST on word k < NWORDS-1: FRAME_ERR pulse, partial frame discarded, index reset to 0, state stays FILL.
  - TLAST absent on word NWORDS-1: FRAME_ERR pulse, but the frame is still committed (length is authoritative) and the state goes to FULL.
- State FULL (LOADED = 1): TREADY = 0; the state holds until TRIG.
- TRIG sampled while EN = 1:
  - In FULL: DATA <= back buffer on the next edge, SWAP = 1 for one cycle, state -> FILL, index = 0.
  - In FILL: DATA <= 0 (blank sweep, never repeat stale targets), UNDERRUN = 1 for one cycle, UNDERRUN_CNT increments. The index and the partial frame are kept and filling continues.
- Latency: DATA changes exactly one cycle after the TRIG-sampling edge. This matches the generator, which resets its bin index to 0 on that same edge.
- Simultaneous TRIG and acceptance of the final word in FILL:
  - The TRIG is handled as FILL, so UNDERRUN fires and DATA is zeroed.
  - The word is still accepted and the state goes to FULL; the frame waits for the next TRIG.
- EN low: synchronous flush on every cycle it is low.
  - DATA = 0, state = FILL, index = 0, TREADY = 0.
  - TRIG is ignored; counters hold.
- Counters saturate at 2^CNT_W-1 and clear only on SYS_RST.

Test Plan:
- Bench uses SIZE=64, WORD_W=32 (NWORDS=2) unless stated.
- Reset and frame load: release reset, EN=1, send 0xAAAA5555 then 0x0F0F00FF with TLAST on the second word -> LOADED=1 after the second handshake, TREADY=0, DATA still 0. Pulse TRIG -> next cycle DATA=64'h0F0F00FF_AAAA5555, SWAP=1 for one cycle, LOADED=0, TREADY=1.
- Underrun: TRIG with only word 0 accepted -> DATA=0, UNDERRUN=1, UNDERRUN_CNT=1. Then send word 1 with TLAST -> LOADED=1, and the next TRIG loads both words intact.
- Early TLAST: send word 0 with TLAST=1 -> FRAME_ERR=1, FRAME_ERR_CNT=1, index=0. Then a correct 2-word frame loads correctly.
- Missing TLAST: send 2 words with TLAST=0 -> FRAME_ERR=1 and LOADED=1; after TRIG, DATA equals those two words.
- Simultaneous TRIG with the final handshake -> UNDERRUN=1, DATA=0, LOADED=1 next cycle; the second TRIG -> SWAP with the frame.
- Defaults (SIZE=3200, NWORDS=100): 100 words, each word = its index -> DATA[31:0]=0, DATA[3199:3168]=99. Also drop EN mid-frame -> DATA=0, TREADY=0, index cleared, and a re-sent frame loads correctly.
